// File: rtl/msx_slot_target.sv
// MSX cartridge slot responder: ASCII8-style mapper, backing-memory fetch over req/ack, WAIT insertion.
// Define MSX_SLOT_WAIT_EN to drive mwait low during fetches and enable the WAIT_MAX timeout.
module msx_slot_target #(
  parameter int BANK_W   = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                msltsl,
  input  logic                mmreq,
  input  logic                miorq,
  input  logic                mrd,
  input  logic                mwr,
  input  logic [15:0]         maddr,
  input  logic [7:0]          mdata_in,
  output logic [7:0]          mdata_out,
  output logic                mdata_oe,
  output logic                mwait,
  output logic                mem_req,
  output logic                mem_we,
  output logic [BANK_W+12:0]  mem_addr,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ack
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRIVE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]        state;
  logic [1:0]        sltsl_s, mreq_s, iorq_s, rd_s, wr_s;
  logic [BANK_W-1:0] bank [4];
  logic [1:0]        wr_idx;
  logic              wr_hit;
  logic [BANK_W-1:0] wr_val;

  // Strobes are asynchronous to clk; everything downstream only sees the second flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sltsl_s <= 2'b11;
      mreq_s  <= 2'b11;
      iorq_s  <= 2'b11;
      rd_s    <= 2'b11;
      wr_s    <= 2'b11;
    end else begin
      sltsl_s <= {sltsl_s[0], msltsl};
      mreq_s  <= {mreq_s[0], mmreq};
      iorq_s  <= {iorq_s[0], miorq};
      rd_s    <= {rd_s[0], mrd};
      wr_s    <= {wr_s[0], mwr};
    end
  end

  logic       mem_cycle, in_window, rd_det, wr_det, released;
  logic [1:0] page;

  assign mem_cycle = ~sltsl_s[1] & ~mreq_s[1] & iorq_s[1];
  assign in_window = ^maddr[15:14];
  assign rd_det    = mem_cycle & ~rd_s[1] & in_window;
  assign wr_det    = mem_cycle & ~wr_s[1];
  assign released  = rd_s[1] | sltsl_s[1];
  assign page      = maddr[14:13] - 2'b10;
  assign mem_we    = 1'b0;

`ifdef MSX_SLOT_WAIT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(WAIT_MAX - 1);
  logic        mwait_q;
  logic [15:0] wait_cnt;
  assign mwait = mwait_q;
`else
  logic unused_cfg;
  assign mwait      = 1'b1;
  assign unused_cfg = ^WAIT_MAX;
`endif

  // A request left open by a timeout or an aborted read is kept until its ack,
  // and no new fetch starts while it is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      for (int i = 0; i < 4; i++) bank[i] <= BANK_W'(i);
      wr_idx    <= 2'b00;
      wr_hit    <= 1'b0;
      wr_val    <= '0;
      mdata_out <= 8'hFF;
      mdata_oe  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
`ifdef MSX_SLOT_WAIT_EN
      mwait_q   <= 1'b1;
      wait_cnt  <= '0;
`endif
    end else begin
      if (state != ST_FETCH && mem_ack) mem_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_det && !mem_req) begin
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= {bank[page], maddr[12:0]};
`ifdef MSX_SLOT_WAIT_EN
            mwait_q  <= 1'b0;
            wait_cnt <= '0;
`endif
          end else if (wr_det) begin
            state  <= ST_WRITE;
            wr_idx <= maddr[12:11];
            wr_hit <= (maddr[15:13] == 3'b011);
            wr_val <= mdata_in[BANK_W-1:0];
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
`ifdef MSX_SLOT_WAIT_EN
            mwait_q <= 1'b1;
`endif
            if (released) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_DRIVE;
              mdata_out <= mem_rdata;
              mdata_oe  <= 1'b1;
            end
          end else if (released) begin
            state <= ST_IDLE;
`ifdef MSX_SLOT_WAIT_EN
            mwait_q <= 1'b1;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state     <= ST_DRIVE;
            mdata_out <= 8'hFF;
            mdata_oe  <= 1'b1;
            mwait_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        ST_DRIVE: begin
          if (released) begin
            state    <= ST_IDLE;
            mdata_oe <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (wr_hit) bank[wr_idx] <= wr_val;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (wr_s[1]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msx_slot_target.sv
// Self-checking bench for msx_slot_target: vector table of bus reads plus hand-written corner sequences.
// Expected mem_addr values go through a scoreboard queue checked when mem_req rises.
module tb_msx_slot_target;

  localparam int BANK_W   = 8;
  localparam int WAIT_MAX = 16;
`ifdef MSX_SLOT_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              msltsl, mmreq, miorq, mrd, mwr;
  logic [15:0]       maddr;
  logic [7:0]        mdata_in;
  logic [7:0]        mdata_out;
  logic              mdata_oe;
  logic              mwait;
  logic              mem_req;
  logic              mem_we;
  logic [BANK_W+12:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] addr;
    logic        io;
    logic [7:0]  rdata;
    int          delay;
    logic        expReq;
    logic [20:0] expAddr;
  } vec_t;

  vec_t vecs [8];
  logic [20:0] expQ [$];
  logic reqPrev = 1'b0;

  msx_slot_target #(.BANK_W(BANK_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .msltsl(msltsl), .mmreq(mmreq), .miorq(miorq), .mrd(mrd), .mwr(mwr),
    .maddr(maddr), .mdata_in(mdata_in),
    .mdata_out(mdata_out), .mdata_oe(mdata_oe), .mwait(mwait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every new memory request must match the next expected address.
  always @(negedge clk) begin
    if (mem_req && !reqPrev) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected_req: got addr 0x%0h, expected no request", mem_addr);
      end else begin
        checkOutput("sb_addr", 32'(mem_addr), 32'(expQ.pop_front()));
      end
    end
    reqPrev = mem_req;
  end

  task automatic releaseBus();
    msltsl = 1'b1; mmreq = 1'b1; miorq = 1'b1; mrd = 1'b1; mwr = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    maddr  = v.addr;
    msltsl = 1'b0;
    mrd    = 1'b0;
    if (v.io) begin miorq = 1'b0; mmreq = 1'b1; end
    else      begin miorq = 1'b1; mmreq = 1'b0; end
    if (v.expReq) expQ.push_back(v.expAddr);
  endtask

  task automatic runRead(input vec_t v, input string tag);
    int lowCount;
    applyStimulus(v);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_req"}, 32'(mem_req), 32'(v.expReq));
    if (v.expReq) begin
      lowCount = 0;
      for (int k = 0; k < v.delay; k++) begin
        if (k > 0) @(negedge clk);
        if (!mwait) lowCount++;
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 8'h00;
      checkOutput({tag, "_wait_cycles"}, 32'(lowCount), WAIT_EN ? 32'(v.delay) : 32'd0);
      checkOutput({tag, "_oe"}, 32'(mdata_oe), 32'd1);
      checkOutput({tag, "_data"}, 32'(mdata_out), 32'(v.rdata));
      checkOutput({tag, "_wait_rel"}, 32'(mwait), 32'd1);
      checkOutput({tag, "_req_drop"}, 32'(mem_req), 32'd0);
      releaseBus();
      repeat (2) @(negedge clk);
      checkOutput({tag, "_oe_hold"}, 32'(mdata_oe), 32'd1);
      @(negedge clk);
      checkOutput({tag, "_oe_off"}, 32'(mdata_oe), 32'd0);
    end else begin
      repeat (3) @(negedge clk);
      checkOutput({tag, "_no_req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, "_no_oe"}, 32'(mdata_oe), 32'd0);
      checkOutput({tag, "_no_wait"}, 32'(mwait), 32'd1);
      releaseBus();
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    maddr = a; mdata_in = d;
    msltsl = 1'b0; mmreq = 1'b0; miorq = 1'b1; mwr = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("wr_no_req", 32'(mem_req), 32'd0);
    releaseBus();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   lowCount;
    logic oeSeen;

    vecs[0] = '{16'h4000, 1'b0, 8'hA5, 4, 1'b1, 21'h00000};
    vecs[1] = '{16'h5FFF, 1'b0, 8'h3C, 1, 1'b1, 21'h01FFF};
    vecs[2] = '{16'h6123, 1'b0, 8'h81, 2, 1'b1, 21'h02123};
    vecs[3] = '{16'h8005, 1'b0, 8'h00, 3, 1'b1, 21'h04005};
    vecs[4] = '{16'hBFFF, 1'b0, 8'hFE, 2, 1'b1, 21'h07FFF};
    vecs[5] = '{16'hC000, 1'b0, 8'h00, 0, 1'b0, 21'h00000};
    vecs[6] = '{16'h3FFF, 1'b0, 8'h00, 0, 1'b0, 21'h00000};
    vecs[7] = '{16'h4000, 1'b1, 8'h00, 0, 1'b0, 21'h00000};

    reset = 1'b1;
    releaseBus();
    maddr = 16'h0000; mdata_in = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data", 32'(mdata_out), 32'hFF);
    checkOutput("rst_oe", 32'(mdata_oe), 32'd0);
    checkOutput("rst_wait", 32'(mwait), 32'd1);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) runRead(vecs[i], $sformatf("vec%0d", i));

    // Mapper writes: only 0x6000-0x7FFF reaches the bank registers.
    busWrite(16'h7000, 8'h12);
    runRead('{16'h8005, 1'b0, 8'h42, 2, 1'b1, 21'h24005}, "map_bank2");
    busWrite(16'h6800, 8'h07);
    runRead('{16'h6010, 1'b0, 8'h17, 1, 1'b1, 21'h0E010}, "map_bank1");
    busWrite(16'h4000, 8'h55);
    runRead('{16'h4000, 1'b0, 8'h99, 2, 1'b1, 21'h00000}, "rom_write_ignored");

    // Read strobe dropped mid-fetch: handshake completes, data bus never driven.
    v = '{16'h4100, 1'b0, 8'h5A, 0, 1'b1, 21'h00100};
    applyStimulus(v);
    repeat (3) @(negedge clk);
    checkOutput("abort_req", 32'(mem_req), 32'd1);
    mrd = 1'b1;
    oeSeen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mdata_oe) oeSeen = 1'b1;
    end
    checkOutput("abort_req_held", 32'(mem_req), 32'd1);
    checkOutput("abort_wait", 32'(mwait), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    @(negedge clk);
    mem_ack = 1'b0;
    if (mdata_oe) oeSeen = 1'b1;
    checkOutput("abort_req_drop", 32'(mem_req), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (mdata_oe) oeSeen = 1'b1;
    end
    checkOutput("abort_oe_never", 32'(oeSeen), 32'd0);
    releaseBus();
    repeat (2) @(negedge clk);
    runRead('{16'h4002, 1'b0, 8'h3A, 2, 1'b1, 21'h00002}, "after_abort");

`ifdef MSX_SLOT_WAIT_EN
    // Memory never answers: WAIT released after WAIT_MAX cycles with 0xFF on the bus.
    v = '{16'h4000, 1'b0, 8'h00, 0, 1'b1, 21'h00000};
    applyStimulus(v);
    repeat (3) @(negedge clk);
    checkOutput("to_req", 32'(mem_req), 32'd1);
    lowCount = 0;
    while (!mwait && lowCount < 40) begin
      lowCount++;
      @(negedge clk);
    end
    checkOutput("to_wait_cycles", 32'(lowCount), 32'(WAIT_MAX));
    checkOutput("to_oe", 32'(mdata_oe), 32'd1);
    checkOutput("to_data", 32'(mdata_out), 32'hFF);
    checkOutput("to_req_held", 32'(mem_req), 32'd1);
    repeat (3) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("to_req_drop", 32'(mem_req), 32'd0);
    checkOutput("to_late_ack_ignored", 32'(mdata_out), 32'hFF);
    releaseBus();
    repeat (3) @(negedge clk);
    checkOutput("to_oe_off", 32'(mdata_oe), 32'd0);
`else
    // Without WAIT support the fetch simply waits for the slow ack.
    runRead('{16'h4000, 1'b0, 8'hC3, 20, 1'b1, 21'h00000}, "slow_ack");
`endif

    // Reset in the middle of a fetch, with an ack arriving on the same edge.
    v = '{16'h8000, 1'b0, 8'h00, 0, 1'b1, 21'h24000};
    applyStimulus(v);
    repeat (3) @(negedge clk);
    checkOutput("rstf_req", 32'(mem_req), 32'd1);
    checkOutput("rstf_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h99;
    releaseBus();
    @(negedge clk);
    checkOutput("rstf_req_off", 32'(mem_req), 32'd0);
    checkOutput("rstf_wait", 32'(mwait), 32'd1);
    checkOutput("rstf_oe", 32'(mdata_oe), 32'd0);
    checkOutput("rstf_addr", 32'(mem_addr), 32'd0);
    checkOutput("rstf_data", 32'(mdata_out), 32'hFF);
    reset = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstf_oe_after", 32'(mdata_oe), 32'd0);
    runRead('{16'h6000, 1'b0, 8'h11, 1, 1'b1, 21'h02000}, "rstf_bank1");
    runRead('{16'h8000, 1'b0, 8'h22, 1, 1'b1, 21'h04000}, "rstf_bank2");

    checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msx_slot_target.md
# msx_slot_target

Cartridge-side responder for the MSX slot bus: it samples slot-select, strobes, address and data driven by an MSX bus master, and serves memory reads in the cartridge window 0x4000–0xBFFF from a backing memory through a req/ack handshake. Bank selection uses an ASCII8-style mapper with four 8 KB bank registers. The block inserts MSX WAIT while a fetch is outstanding and drives the data bus only for the duration of a selected read. It sits between the cartridge edge connector pins and on-board ROM/flash/SDRAM controllers.

## Interface
Parameters:
- BANK_W, 8, width of each bank register; mem_addr width is BANK_W+13
- WAIT_MAX, 255, cycles a fetch may hold WAIT before timeout (1..65535)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- msltsl  in  1  slot select, active low, asynchronous to clk
- mmreq  in  1  memory request, active low, async
- miorq  in  1  I/O request, active low, async; I/O cycles are never answered
- mrd  in  1  read strobe, active low, async
- mwr  in  1  write strobe, active low, async
- maddr  in  16  bus address
- mdata_in  in  8  bus data from master
- mdata_out  out  8  read data toward bus
- mdata_oe  out  1  high = drive mdata_out onto bus
- mwait  out  1  MSX WAIT, active low
- mem_req  out  1  backing-memory request, level
- mem_we  out  1  1 = write (always 0 in this block; reserved)
- mem_addr  out  BANK_W+13  {bank, maddr[12:0]}
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse

## Operation
- msltsl, mmreq, miorq, mrd, mwr: two-flop synchronizers; maddr/mdata_in captured in the cycle a cycle is detected (bus holds them stable during strobe).
- Read cycle detected: synced msltsl=0, mmreq=0, mrd=0, miorq=1, maddr in 0x4000–0xBFFF.
- Write cycle detected: synced msltsl=0, mmreq=0, mwr=0, miorq=1.
- Page = maddr[14:13] − 2'b10 mod 4: 0x4000→bank0, 0x6000→bank1, 0x8000→bank2, 0xA000→bank3.
- Mapper write: maddr in 0x6000–0x7FFF; register index = maddr[12:11]; value = mdata_in[BANK_W-1:0]. Writes elsewhere ignored (ROM).
- FSM states:
  - IDLE: on read → FETCH (mem_req=1, mwait=0, counter cleared); on write → WRITE.
  - FETCH: hold mem_req/mem_addr; on mem_ack → DRIVE with mdata_out=mem_rdata; when counter reaches WAIT_MAX → DRIVE with mdata_out=0xFF, mem_req held until ack then dropped (handshake never abandoned).
  - DRIVE: mdata_oe=1, mwait=1; when synced mrd or msltsl goes high → IDLE, mdata_oe=0 the same cycle the deassert is seen.
  - WRITE: update bank register once; → HOLD.
  - HOLD: wait for synced mwr high → IDLE.
- Strobe released during FETCH: finish handshake, go to IDLE without asserting mdata_oe.
- Reset values: bank0..3 = 0,1,2,3; mdata_out=0xFF; mdata_oe=0; mwait=1; mem_req=0; mem_we=0; mem_addr=0; FSM=IDLE.
- Reset mid-operation: all of the above next edge; pending mem_ack ignored.

## Timing
- Strobe low → detect: 2 clk (synchronizer) + 1 clk compare; mem_req and mwait=0 asserted on the 3rd rising edge after strobe falls.
- mem_ack at edge N → mdata_out valid, mdata_oe=1, mwait=1 at edge N+1.
- Bank register write visible to a read decoded at edge N+2 after WRITE entry.
- mem_ack while not in FETCH: ignored.
- Counter saturates; timeout at exactly WAIT_MAX cycles in FETCH.
- Back-to-back cycles: IDLE must be re-entered (strobe seen high) before next detect; no cycle detected twice.

## Configuration
- MSX_SLOT_WAIT_EN defined: mwait driven as above, timeout active.
- Undefined: mwait constant 1, WAIT_MAX counter removed; FETCH waits for mem_ack indefinitely and DRIVE follows; backing memory must answer within the master's read strobe window.

## Test plan
- Reset, read 0x4000 with mem_ack after 4 cycles, mem_rdata=0xA5 → mem_addr=0x00000, mwait low 4 cycles, mdata_out=0xA5 with oe=1 until mrd rises.
- Write 0x7000←0x12, then read 0x8005 → mem_addr=0x24005 ({0x12,0x0005}).
- Read 0xC000 or I/O read (miorq=0) → no mem_req, mdata_oe stays 0.
- With MSX_SLOT_WAIT_EN, WAIT_MAX=16, mem_ack never → mwait released after 16 cycles, mdata_out=0xFF driven.
- Assert reset during FETCH → next edge mem_req=0, mwait=1, oe=0, banks=0,1,2,3.
- Drop mrd during FETCH, ack arrives → FSM returns to IDLE, mdata_oe never asserted.
